// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding and the four SPI modes.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL
  } state_t;

  // Mode constants are {cpol, cpha}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic logic sample_on_leading(input logic [1:0] mode);
    return (mode == MODE0) || (mode == MODE2);
  endfunction

  function automatic logic shift_on_leading(input logic [1:0] mode);
    return (mode == MODE1) || (mode == MODE3);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: one-cycle tick every div+1 cycles while enabled.
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;

  assign tick = en && (cnt_reg == '0);

  // While disabled the counter tracks the reload value, so the first
  // half-period after enable rises is already full length.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (!en || tick) begin
      cnt_reg <= div;
    end else begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Full-duplex SPI master with start/busy/done handshake, all four modes,
// selectable bit order, programmable SCLK divider and one-hot chip selects.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 8,
  parameter int NUM_CS = 4,
  parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int EDGES = 2 * DATA_W;
  localparam int EC_W  = $clog2(EDGES + 1);

  state_t            state_reg;
  logic [DIV_W-1:0]  div_reg;
  logic [1:0]        mode_reg;
  logic              lsb_reg;
  logic [DATA_W-1:0] tx_sr_reg;
  logic [DATA_W-1:0] rx_sr_reg;
  logic [EC_W-1:0]   edge_cnt_reg;

  logic [NUM_CS-1:0] cs_n_next;
  logic [DIV_W-1:0]  div_src;
  logic              tick;
  logic [EC_W-1:0]   edge_next;
  logic              leading;
  logic              last_edge;
  logic              do_sample;
  logic              do_shift;
  logic [DATA_W-1:0] tx_shifted;
  logic [DATA_W-1:0] rx_shifted;

  // Out-of-range cs_sel matches no line, leaving every select deasserted.
  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
    assign cs_n_next[gi] = (cs_sel != CS_W'(gi));
  end

  assign div_src = (state_reg == IDLE) ? clk_div : div_reg;

  spi_clk_gen #(
    .DIV_W(DIV_W)
  ) u_clk_gen (
    .clk (clk),
    .rst (rst),
    .en  (busy),
    .div (div_src),
    .tick(tick)
  );

  // Edge numbering starts at 1: odd edges are leading, even edges trailing.
  assign edge_next  = edge_cnt_reg + EC_W'(1);
  assign leading    = edge_next[0];
  assign last_edge  = (edge_next == EC_W'(EDGES));
  assign do_sample  = sample_on_leading(mode_reg) ? leading : !leading;
  assign do_shift   = shift_on_leading(mode_reg) ? (leading && (edge_next != EC_W'(1)))
                                                 : (!leading && !last_edge);
  assign tx_shifted = lsb_reg ? (tx_sr_reg >> 1) : (tx_sr_reg << 1);
  assign rx_shifted = lsb_reg ? {spi_miso, rx_sr_reg[DATA_W-1:1]}
                              : {rx_sr_reg[DATA_W-2:0], spi_miso};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      div_reg      <= '0;
      mode_reg     <= MODE0;
      lsb_reg      <= 1'b0;
      tx_sr_reg    <= '0;
      rx_sr_reg    <= '0;
      edge_cnt_reg <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rx_data      <= '0;
      spi_cs_n     <= '1;
      spi_sclk     <= 1'b0;
      spi_mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          spi_sclk <= cpol;
          if (start) begin
            state_reg    <= LEAD;
            busy         <= 1'b1;
            div_reg      <= clk_div;
            mode_reg     <= {cpol, cpha};
            lsb_reg      <= lsb_first;
            tx_sr_reg    <= tx_data;
            edge_cnt_reg <= '0;
            spi_cs_n     <= cs_n_next;
            spi_mosi     <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
          end
        end
        LEAD, SHIFT: begin
          if (tick) begin
            // After the final edge one more half-period passes before TRAIL.
            if (edge_cnt_reg == EC_W'(EDGES)) begin
              state_reg <= TRAIL;
            end else begin
              state_reg    <= SHIFT;
              edge_cnt_reg <= edge_next;
              spi_sclk     <= ~spi_sclk;
              if (do_sample) begin
                rx_sr_reg <= rx_shifted;
              end
              if (do_shift) begin
                tx_sr_reg <= tx_shifted;
                spi_mosi  <= lsb_reg ? tx_shifted[0] : tx_shifted[DATA_W-1];
              end
            end
          end
        end
        TRAIL: begin
          if (tick) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            spi_cs_n  <= '1;
            rx_data   <= rx_sr_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed and randomized transfers against a cycle-level timing model and a
// behavioural SPI slave.
module tb_spi_master;

  localparam int DW  = 16;
  localparam int NCS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] tx_data = '0;
  logic [2:0]  cs_sel = '0;
  logic [7:0]  clk_div = '0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic        lsb_first = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] rx_data;
  logic [3:0]  spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  wire         spi_miso;

  logic        loopback = 1'b0;
  logic        slave_miso = 1'b0;

  int checks = 0;
  int errors = 0;

  assign spi_miso = loopback ? spi_mosi : slave_miso;

  always #5 clk = ~clk;

  spi_master #(
    .DATA_W(DW),
    .DIV_W (8),
    .NUM_CS(NCS),
    .CS_W  (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tx_data  (tx_data),
    .cs_sel   (cs_sel),
    .clk_div  (clk_div),
    .cpol     (cpol),
    .cpha     (cpha),
    .lsb_first(lsb_first),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  // Behavioural slave: drives MISO and captures MOSI per SPI mode rules.
  logic [15:0] s_word = '0;
  logic [15:0] s_rx = '0;
  logic        s_cpha = 1'b0;
  logic        s_lsb = 1'b0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs_low = 1'b0;
  int          s_edge = 0;
  int          s_out = 0;
  int          s_in = 0;

  function automatic logic pick(input logic [15:0] w, input int j, input logic lsb);
    return lsb ? w[j] : w[15-j];
  endfunction

  always @(negedge clk) begin : slave
    logic cs_low;
    cs_low = (spi_cs_n != 4'hF);
    if (cs_low && !prev_cs_low) begin
      s_edge = 0;
      s_out = 0;
      s_in = 0;
      s_rx = '0;
      slave_miso = pick(s_word, 0, s_lsb);
    end else if (cs_low && (spi_sclk !== prev_sclk)) begin
      s_edge++;
      if (((s_edge % 2) == 1) != s_cpha) begin
        if (s_in < 16) s_rx[s_lsb ? s_in : 15 - s_in] = spi_mosi;
        s_in++;
      end else if (s_edge != 1 && s_edge != 2 * DW && s_out < 15) begin
        s_out++;
        slave_miso = pick(s_word, s_out, s_lsb);
      end
    end
    prev_sclk = spi_sclk;
    prev_cs_low = cs_low;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a falling clock edge.
  task automatic run_xfer(input string tag, input logic [15:0] tx, input int cs, input int div,
                          input logic pol, input logic pha, input logic lsb, input logic loop,
                          input logic [15:0] sword, input logic pre_started,
                          input logic mid_start, input logic chain);
    int h, exp_done, done_at, e, j;
    int bad_sclk, bad_mosi, bad_cs, bad_busy;
    logic [3:0] exp_cs;
    logic exp_mosi;
    h = div + 1;
    exp_done = 1 + (2 * DW + 2) * h;
    done_at = 0;
    bad_sclk = 0; bad_mosi = 0; bad_cs = 0; bad_busy = 0;
    exp_cs = (cs < NCS) ? ~(4'b0001 << cs) : 4'hF;
    s_word = sword; s_cpha = pha; s_lsb = lsb; loopback = loop;
    if (!pre_started) begin
      tx_data = tx; cs_sel = 3'(cs); clk_div = 8'(div);
      cpol = pol; cpha = pha; lsb_first = lsb;
      start = 1'b1;
    end
    for (int n = 1; n <= exp_done + 4 && done_at == 0; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (mid_start && n == 10) begin start = 1'b1; tx_data = ~tx; cs_sel = 3'd1; cpol = ~pol; end
      if (mid_start && n == 11) begin start = 1'b0; tx_data = tx; cs_sel = 3'(cs); cpol = pol; end
      if (done) begin
        done_at = n;
      end else begin
        e = (n - 1) / h;
        if (e > 2 * DW) e = 2 * DW;
        j = pha ? ((e <= 1) ? 0 : (e - 1) / 2) : e / 2;
        if (j > DW - 1) j = DW - 1;
        exp_mosi = pick(tx, j, lsb);
        if (spi_sclk !== (pol ^ ((e % 2) == 1))) bad_sclk++;
        if (spi_mosi !== exp_mosi) bad_mosi++;
        if (spi_cs_n !== exp_cs) bad_cs++;
        if (busy !== 1'b1) bad_busy++;
      end
    end
    check({tag, "/done_cycle"}, done_at, exp_done);
    check({tag, "/busy_at_done"}, {31'd0, busy}, 0);
    check({tag, "/cs_at_done"}, {28'd0, spi_cs_n}, 4'hF);
    check({tag, "/sclk_idle_after"}, {31'd0, spi_sclk}, {31'd0, pol});
    check({tag, "/sclk_bad_cycles"}, bad_sclk, 0);
    check({tag, "/mosi_bad_cycles"}, bad_mosi, 0);
    check({tag, "/cs_bad_cycles"}, bad_cs, 0);
    check({tag, "/busy_bad_cycles"}, bad_busy, 0);
    if (loop) begin
      check({tag, "/rx_loopback"}, {16'd0, rx_data}, {16'd0, tx});
    end else if (cs < NCS) begin
      check({tag, "/rx_from_slave"}, {16'd0, rx_data}, {16'd0, sword});
      check({tag, "/slave_got_tx"}, {16'd0, s_rx}, {16'd0, tx});
    end
    $display("xfer %s tx=%h cs=%0d div=%0d mode=%0d lsb=%0d rx=%h done_at=%0d",
             tag, tx, cs, div, {pol, pha}, lsb, rx_data, done_at);
    if (chain) begin
      start = 1'b1;
    end else begin
      @(negedge clk);
      check({tag, "/done_one_cycle"}, {31'd0, done}, 0);
      check({tag, "/cs_idle"}, {28'd0, spi_cs_n}, 4'hF);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset/busy", {31'd0, busy}, 0);
    check("reset/done", {31'd0, done}, 0);
    check("reset/rx_data", {16'd0, rx_data}, 0);
    check("reset/cs_n", {28'd0, spi_cs_n}, 4'hF);
    check("reset/sclk", {31'd0, spi_sclk}, 0);
    check("reset/mosi", {31'd0, spi_mosi}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_xfer("mode0_loop", 16'hA5C3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_xfer("mode1", 16'h8001, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3C5A, 1'b0, 1'b0, 1'b0);
    run_xfer("mode2", 16'h8001, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3C5A, 1'b0, 1'b0, 1'b0);
    run_xfer("mode3", 16'h8001, 3, 2, 1'b1, 1'b1, 1'b0, 1'b0, 16'h3C5A, 1'b0, 1'b0, 1'b0);
    run_xfer("lsb_div3", 16'h0001, 0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    run_xfer("cs2", 16'h1357, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9ACE, 1'b0, 1'b0, 1'b0);
    run_xfer("cs5", 16'h2468, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b0);
    run_xfer("busy_start", 16'h1234, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
    run_xfer("done_start", 16'h1234, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a transfer.
    tx_data = 16'hFFFF; cs_sel = 3'd0; clk_div = 8'd0;
    cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; loopback = 1'b1;
    start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst/busy", {31'd0, busy}, 0);
    check("midrst/done", {31'd0, done}, 0);
    check("midrst/rx_data", {16'd0, rx_data}, 0);
    check("midrst/cs_n", {28'd0, spi_cs_n}, 4'hF);
    check("midrst/sclk", {31'd0, spi_sclk}, 0);
    rst = 1'b0;
    @(negedge clk);
    $display("xfer midrst reset at cycle 10, busy=%0d cs_n=%h rx=%h", busy, spi_cs_n, rx_data);
    run_xfer("after_rst", 16'h5AA5, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      logic [15:0] rtx, rsw;
      logic [1:0] rmode;
      rtx = 16'($urandom);
      rsw = 16'($urandom);
      rmode = 2'($urandom_range(0, 3));
      run_xfer($sformatf("rand%0d", r), rtx, int'($urandom_range(0, 4)),
               int'($urandom_range(0, 3)), rmode[1], rmode[0], 1'($urandom_range(0, 1)),
               1'b0, rsw, 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Parametrised full-duplex SPI master: the next-generation replacement for the fixed 16-bit, MOSI-only, free-running SPI state machine. Adds a start/busy/done handshake, configurable word width, programmable SCLK divider, all four SPI modes, MSB/LSB-first order, MISO capture, and multiple one-hot chip selects. Sits between a register or host interface and the external SPI pins.

## Interface
- DATA_W, 16: bits per transfer (≥2)
- DIV_W, 8: width of clk_div
- NUM_CS, 4: number of chip-select lines (≥1)
- CS_W, $clog2(NUM_CS) (min 1): width of cs_sel
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request transfer; accepted only when busy=0
- tx_data  in  DATA_W  word to shift out
- cs_sel  in  CS_W  index of chip select to assert
- clk_div  in  DIV_W  half-period of SCLK = clk_div+1 clk cycles
- cpol  in  1  SCLK idle level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- lsb_first  in  1  1: bit 0 first; 0: bit DATA_W-1 first
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- rx_data  out  DATA_W  word captured from MISO; valid from done, held until next done
- spi_cs_n  out  NUM_CS  active-low chip selects
- spi_sclk  out  1  serial clock
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in (synchronous to clk; no synchroniser inside)

## Operation
- States: IDLE, LEAD, SHIFT, TRAIL.
- IDLE: spi_cs_n all 1; spi_sclk registered from cpol input; busy=0. On start=1, latch tx_data, cs_sel, clk_div, cpol, cpha, lsb_first; go to LEAD. Config inputs are ignored during busy=1.
- LEAD: selected spi_cs_n low, busy=1, spi_mosi = first bit. Lasts H = clk_div+1 cycles; then SHIFT.
- SHIFT: spi_sclk toggles every H cycles, 2·DATA_W edges total. Odd edges are leading, even edges trailing.
  - cpha=0: sample MISO on leading edges; advance MOSI on trailing edges except the last.
  - cpha=1: advance MOSI on leading edges (first leading edge presents bit 0 of sequence); sample MISO on trailing edges.
- TRAIL: SCLK at cpol, CS still low, H cycles. Then: spi_cs_n all high, rx_data updated, done=1 for one cycle, busy=0, return to IDLE.
- Received bits are assembled in the same order as transmitted: with lsb_first=1, first received bit lands in rx_data[0].
- cs_sel ≥ NUM_CS: transfer runs with full timing and done, but all spi_cs_n stay high.
- start while busy=1: ignored, no queueing.
- start in the done cycle: accepted; guarantees CS high for ≥1 clk between transfers.
- rst mid-transfer: on next edge all outputs to reset values, no done pulse, rx_data cleared.

## Timing
- Reset values: busy 0, done 0, rx_data 0, spi_cs_n all 1, spi_sclk 0, spi_mosi 0.
- start sampled at cycle 0 → CS low and busy=1 at cycle 1.
- First SCLK edge at cycle 1+H; edge k at cycle 1+k·H (k = 1..2·DATA_W).
- done at cycle 1+(2·DATA_W+2)·H.
- Example DATA_W=16, clk_div=0 (H=1): done at cycle 35; clk_div=3 (H=4): done at cycle 137.
- MOSI changes only on clk edges coinciding with SCLK edges or CS assertion; never on a sampling edge.

## Structure
- Package spi_pkg: state enum (IDLE, LEAD, SHIFT, TRAIL), SPI mode constants (MODE0..MODE3 as {cpol,cpha}).
- Sub-module spi_clk_gen: half-period down-counter from latched clk_div, emits one-cycle tick every H cycles while enabled; reloads on enable rise.
- Top holds FSM, edge counter ($clog2(2·DATA_W+1) bits), TX shift register, RX shift register, CS decode.

## Test plan
- Mode 0, DATA_W=16, clk_div=0, MSB-first, tx 16'hA5C3, MISO loopback from MOSI → rx_data 16'hA5C3, done at cycle 35, spi_cs_n[0] low cycles 1–34.
- Modes 1/2/3 each with tx 16'h8001, slave model returning 16'h3C5A → rx_data 16'h3C5A; SCLK idle = cpol before and after; sampling edge per cpha checked.
- lsb_first=1, tx 16'h0001, clk_div=3 → MOSI high during first bit period only, first SCLK edge at cycle 5, done at cycle 137.
- cs_sel=2 then cs_sel=5 (NUM_CS=4) → only spi_cs_n[2] asserts; second transfer completes with done but spi_cs_n stays 4'hF.
- start pulsed during busy and again in done cycle → mid-transfer start ignored (single done); done-cycle start begins new transfer with CS high exactly 1 cycle.
- rst asserted at cycle 10 of a transfer → next cycle busy 0, spi_cs_n all 1, no done, rx_data 0; subsequent start behaves normally.
